// File: rtl/nios_flag_pio_irq.sv
// Avalon-MM flag PIO: synchronized, optionally debounced inputs with
// edge capture, per-bit interrupt mask and a level interrupt output.

// Per-bit debounce filter: output follows the input only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles.
module nios_flag_pio_irq_db #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_i,
  output logic filt_o
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Count consecutive differing cycles; any agreement discards the count.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_i == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      filt_d = sync_i;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter and filtered value registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
endmodule

module nios_flag_pio_irq #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_last, filt, filt_dly_q, edge_w;
  logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d, clr_w;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^{writedata, 1'b0};

  // Input synchronizer chain; stage 0 samples the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_nodb
    assign filt = sync_last;
  end else begin : g_db
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      nios_flag_pio_irq_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk    (clk),
        .reset_n(reset_n),
        .sync_i (sync_last[b]),
        .filt_o (filt[b])
      );
    end
  end

  // Edge selection on the filtered value against its one-cycle delay.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_w = filt & ~filt_dly_q;
      1:       edge_w = ~filt & filt_dly_q;
      default: edge_w = filt ^ filt_dly_q;
    endcase
  end

  // Register updates; a new edge wins over a same-cycle write-1-to-clear.
  always_comb begin
    mask_d = mask_q;
    clr_w  = '0;
    if (wr && address == 2'd1) mask_d = writedata[WIDTH-1:0];
    if (wr && address == 2'd3) clr_w  = writedata[WIDTH-1:0];
    cap_d = (cap_q & ~clr_w) | edge_w;
  end

  // Read mux, zero-extended above WIDTH; reserved address reads zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = filt;
      2'd1:    rd_mux[WIDTH-1:0] = mask_q;
      2'd3:    rd_mux[WIDTH-1:0] = cap_q;
      default: rd_mux = '0;
    endcase
  end

  // Bus-visible state and the delayed filtered value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_dly_q <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata   <= '0;
    end else begin
      filt_dly_q <= filt;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata   <= rd_mux;
    end
  end

  assign irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_nios_flag_pio_irq.sv
// Directed bench over four configurations of the flag PIO sharing one bus.
module tb_nios_flag_pio_irq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic [3:0]  cs = '0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [1:0]  in0 = '0, in1 = '0;
  logic [7:0]  in2 = 8'hFF;
  logic [31:0] in3 = '0;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  nios_flag_pio_irq u0 (.clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
    .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));
  nios_flag_pio_irq #(.DEBOUNCE_CYCLES(4)) u1 (.clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs[1]), .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1));
  nios_flag_pio_irq #(.WIDTH(8), .EDGE_TYPE(1)) u2 (.clk(clk), .reset_n(reset_n),
    .address(address), .chipselect(cs[2]), .write_n(write_n), .writedata(writedata),
    .in_port(in2), .readdata(rd2), .irq(irq2));
  nios_flag_pio_irq #(.WIDTH(32)) u3 (.clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs[3]), .write_n(write_n), .writedata(writedata), .in_port(in3),
    .readdata(rd3), .irq(irq3));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [1:0] a, input logic [31:0] d);
    cs = 4'(1 << idx);
    address = a;
    write_n = 1'b0;
    writedata = d;
    tick();
    cs = '0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    #2;
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_irq0", {31'h0, irq0}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(4);

    // defaults: mask, rising edge latency, capture readback
    wr(0, 2'd1, 32'hFFFF_FFFF);
    rd(2'd1);
    chk("mask0_rb", rd0, 32'h3);
    rd(2'd3);
    chk("cap2_none_after_rise", rd2, 32'h0);
    in0 = 2'b01;
    tick(2);
    chk("irq0_k1", {31'h0, irq0}, 32'h0);
    address = 2'd0;
    tick();
    chk("data0_k2", rd0, 32'h1);
    chk("irq0_k2", {31'h0, irq0}, 32'h1);
    rd(2'd3);
    chk("cap0", rd0, 32'h1);

    // clear coinciding with a new edge: set wins
    in0 = 2'b00;
    tick(3);
    in0 = 2'b01;
    tick(2);
    wr(0, 2'd3, 32'h1);
    rd(2'd3);
    chk("cap0_set_wins", rd0, 32'h1);
    wr(0, 2'd3, 32'h0);
    rd(2'd3);
    chk("cap0_wr0_keeps", rd0, 32'h1);
    wr(0, 2'd3, 32'h1);
    rd(2'd3);
    chk("cap0_cleared", rd0, 32'h0);
    chk("irq0_cleared", {31'h0, irq0}, 32'h0);

    // debounce 4: 3-cycle glitch rejected, 4-cycle pulse accepted
    in1 = 2'b10;
    tick(3);
    in1 = 2'b00;
    tick(8);
    rd(2'd0);
    chk("db_glitch_data", rd1, 32'h0);
    rd(2'd3);
    chk("db_glitch_cap", rd1, 32'h0);
    in1 = 2'b10;
    tick(4);
    in1 = 2'b00;
    tick(10);
    rd(2'd3);
    chk("db_pulse_cap", rd1, 32'h2);
    rd(2'd0);
    chk("db_pulse_back", rd1, 32'h0);
    in1 = 2'b10;
    tick(8);
    rd(2'd0);
    chk("db_hold_data", rd1, 32'h2);

    // falling edge, mask gating of irq
    in2 = 8'h7F;
    tick(4);
    rd(2'd3);
    chk("fall_cap2", rd2, 32'h80);
    chk("irq2_masked", {31'h0, irq2}, 32'h0);
    wr(2, 2'd1, 32'h80);
    chk("irq2_unmasked", {31'h0, irq2}, 32'h1);

    // full width mask and reserved address
    wr(3, 2'd1, 32'hFFFF_FFFF);
    rd(2'd1);
    chk("mask3_rb", rd3, 32'hFFFF_FFFF);
    wr(3, 2'd2, 32'h1234_5678);
    rd(2'd2);
    chk("rsvd3", rd3, 32'h0);

    // asynchronous reset with pending captures
    wr(0, 2'd1, 32'h3);
    in0 = 2'b11;
    tick(3);
    chk("irq0_pre_rst", {31'h0, irq0}, 32'h1);
    rd(2'd3);
    chk("cap0_pre_rst", rd0, 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_irq0_async", {31'h0, irq0}, 32'h0);
    chk("rst_rd0_async", rd0, 32'h0);
    chk("rst_irq2_async", {31'h0, irq2}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    rd(2'd1);
    chk("rst_mask0", rd0, 32'h0);
    chk("rst_mask3", rd3, 32'h0);
    address = 2'd0;
    tick(2);
    chk("db_restart_low", rd1, 32'h0);
    tick(6);
    rd(2'd3);
    chk("held_high_cap0", rd0, 32'h3);
    chk("held_irq0_masked", {31'h0, irq0}, 32'h0);
    rd(2'd0);
    chk("db_restart_high", rd1, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
